// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART transmit arbiter.
package uart_arb_pkg;

    // Arbiter frame-ownership states
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWaitDone = 2'd2
    } arb_state_e;

    // Width of a requester index; at least one bit
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must reach cyc-1
    function automatic int unsigned cnt_width(input int unsigned cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request at or above ptr, wrapping.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Scan offsets from the far end so the nearest offset to ptr wins last
    always_comb begin
        any    = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NUM_REQ)) begin
                sum = sum - (ID_W + 1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among several byte producers.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 262144,
    localparam int unsigned ID_W = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_en,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic [ID_W-1:0]           grant_id,
    output logic                      active,
    output logic                      timeout_err
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic                tx_en_q, tx_en_d;
    logic                active_q, active_d;
    logic                terr_q, terr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                pick_any;
    logic [ID_W-1:0]     pick_id;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_id)
    );

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        ready_d  = '0;
        tx_en_d  = tx_en_q;
        active_d = active_q;
        terr_d   = 1'b0;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                tx_en_d = 1'b0;
                if (pick_any) begin
                    ready_d  = NUM_REQ'(1) << pick_id;
                    data_d   = req_data[pick_id * DATA_W +: DATA_W];
                    grant_d  = pick_id;
                    ptr_d    = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
                    active_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                tx_en_d = 1'b1;
                // Busy/done only mean something once tx_en has actually been presented
                if (tx_en_q && tx_done) begin
                    tx_en_d  = 1'b0;
                    active_d = 1'b0;
                    state_d  = StIdle;
                end else if (tx_en_q && tx_busy) begin
                    tx_en_d = 1'b0;
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                tx_en_d = 1'b0;
                if (tx_done) begin
                    active_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: begin
                tx_en_d  = 1'b0;
                active_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
        // Abort a frame that overran its budget; a normal completion wins the tie
        if (state_q != StIdle && state_d != StIdle && cnt_q == CNT_LAST) begin
            terr_d   = 1'b1;
            tx_en_d  = 1'b0;
            active_d = 1'b0;
            state_d  = StIdle;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            ready_q  <= '0;
            tx_en_q  <= 1'b0;
            active_q <= 1'b0;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            tx_en_q  <= tx_en_d;
            active_q <= active_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready   = ready_q;
    assign tx_en       = tx_en_q;
    assign tx_data     = data_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign timeout_err = terr_q;

endmodule
